// File: rtl/mdp_pcm_sched.sv
// PCM ring-buffer sequencer: sector refill requests, fill-level tracking, play/underrun control.
// Optional low-watermark interrupt built when MDP_PCM_SCHED_LOWIRQ_EN is defined.
module mdp_pcm_sched #(
   parameter int BUF_AW     = 13,
   parameter int SECT_BYTES = 2352,
   parameter int PRIME_SECT = 2,
   parameter int LOW_WM     = 2352
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [15:0]       sect_total,
   input  logic              pcm_we,
   input  logic              smp_rd,
   output logic              fill_req,
   input  logic              fill_ack,
   output logic              pcm_play,
   output logic              pcm_addr_rst,
   output logic              busy,
   output logic              done,
   output logic              underrun,
   output logic              low_irq,
   output logic [BUF_AW:0]   level
);

   localparam int LW = BUF_AW + 1;
   localparam logic [BUF_AW:0] CAP_L    = LW'(2 ** BUF_AW);
   localparam logic [BUF_AW:0] SECT_L   = LW'(SECT_BYTES);
   localparam logic [BUF_AW:0] RESUME_L = LW'(PRIME_SECT * SECT_BYTES);
   localparam logic [BUF_AW:0] SMP_L    = LW'(4);
   localparam logic [7:0]      PRIME_L  = 8'(PRIME_SECT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_PLAY,
      S_UNDERRUN,
      S_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [BUF_AW:0]   level_q, level_d;
   logic [15:0]       sect_left_q, sect_left_d;
   logic [15:0]       sect_total_q, sect_total_d;
   logic [7:0]        ack_cnt_q, ack_cnt_d;
   logic              req_q, req_d;
   logic              underrun_q, underrun_d;
   logic              pcm_play_q, pcm_play_d;

   logic              start_ok;
   logic              ack_vld;
   logic              byte_in;
   logic              smp_out;
   logic              req_ok;
   logic [BUF_AW:0]   free;

   assign start_ok = start && (sect_total != 16'd0);
   // An ack only counts against a request that is still outstanding.
   assign ack_vld  = fill_ack && req_q;
   assign byte_in  = pcm_we && (level_q != CAP_L);
   assign smp_out  = smp_rd && pcm_play_q && (level_q >= SMP_L);
   assign free     = CAP_L - level_q;
   assign req_ok   = (state_q inside {S_PRIME, S_PLAY, S_UNDERRUN}) &&
                     (sect_left_q != 16'd0) && (free >= SECT_L);

   always_comb begin
      state_d      = state_q;
      level_d      = level_q + {{BUF_AW{1'b0}}, byte_in} - (smp_out ? SMP_L : '0);
      sect_left_d  = sect_left_q;
      sect_total_d = sect_total_q;
      ack_cnt_d    = ack_cnt_q;
      req_d        = req_q;
      underrun_d   = underrun_q;
      pcm_play_d   = (state_q == S_PLAY);

      // Dropping on the ack cycle guarantees at least one low cycle before re-raising.
      if (req_q) begin
         if (fill_ack) req_d = 1'b0;
      end else if (req_ok) begin
         req_d = 1'b1;
      end

      if (ack_vld) begin
         sect_left_d = sect_left_q - 16'd1;
         if ((sect_left_q == 16'd1) && loop_en) sect_left_d = sect_total_q;
      end

      unique case (state_q)
         S_IDLE: ;
         S_PRIME: begin
            if (ack_vld) ack_cnt_d = ack_cnt_q + 8'd1;
            if ((ack_vld && (ack_cnt_q + 8'd1 == PRIME_L)) ||
                ((sect_left_q == 16'd0) && !req_q))
               state_d = S_PLAY;
         end
         S_PLAY: begin
            if (level_q < SMP_L) begin
               if (sect_left_q != 16'd0) begin
                  state_d    = S_UNDERRUN;
                  underrun_d = 1'b1;
               end else if (!req_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_UNDERRUN: begin
            if ((level_q >= RESUME_L) || ((sect_left_q == 16'd0) && !req_q))
               state_d = S_PLAY;
         end
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Stop beats everything; a start while busy restarts from scratch.
      if (stop) begin
         state_d     = S_IDLE;
         req_d       = 1'b0;
         level_d     = '0;
         sect_left_d = 16'd0;
         ack_cnt_d   = 8'd0;
      end else if (start_ok) begin
         state_d      = S_PRIME;
         req_d        = 1'b0;
         level_d      = '0;
         sect_left_d  = sect_total;
         sect_total_d = sect_total;
         ack_cnt_d    = 8'd0;
         underrun_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         level_q      <= '0;
         sect_left_q  <= 16'd0;
         sect_total_q <= 16'd0;
         ack_cnt_q    <= 8'd0;
         req_q        <= 1'b0;
         underrun_q   <= 1'b0;
         pcm_play_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         sect_left_q  <= sect_left_d;
         sect_total_q <= sect_total_d;
         ack_cnt_q    <= ack_cnt_d;
         req_q        <= req_d;
         underrun_q   <= underrun_d;
         pcm_play_q   <= pcm_play_d;
      end
   end

`ifdef MDP_PCM_SCHED_LOWIRQ_EN
   localparam logic [BUF_AW:0] LOW_L = LW'(LOW_WM);
   logic low_irq_q, low_irq_d;

   // Forced clears from stop/start are not a drain crossing.
   always_comb begin
      low_irq_d = (state_q == S_PLAY) && !stop && !start_ok &&
                  (level_q >= LOW_L) && (level_d < LOW_L);
   end

   always_ff @(posedge clk) begin
      if (rst) low_irq_q <= 1'b0;
      else     low_irq_q <= low_irq_d;
   end

   assign low_irq = low_irq_q;
`else
   // Constant false for any legal watermark; no level comparator exists in this build.
   assign low_irq = (LOW_WM < 0);
`endif

   assign fill_req     = req_q;
   assign pcm_play     = pcm_play_q;
   assign pcm_addr_rst = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DRAIN);
   assign underrun     = underrun_q;
   assign level        = level_q;

endmodule

// File: tb/tb_mdp_pcm_sched.sv
// Bench for mdp_pcm_sched: directed scenarios with randomized byte/sample traffic,
// checked against a byte-count model of the buffer level and expected control behaviour.
module tb_mdp_pcm_sched;

   localparam int CAP    = 8192;
   localparam int SECT   = 2352;
   localparam int LOWWM  = 2352;
`ifdef MDP_PCM_SCHED_LOWIRQ_EN
   localparam int IRQ_ON = 1;
`else
   localparam int IRQ_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [15:0] sect_total = 16'd0;
   logic        pcm_we = 1'b0;
   logic        smp_rd = 1'b0;
   logic        fill_ack = 1'b0;
   logic        fill_req, pcm_play, pcm_addr_rst, busy, done, underrun, low_irq;
   logic [13:0] level;

   int n_tests = 0;
   int n_fail  = 0;
   int m_level = 0;     // bytes the model believes are buffered
   bit exp_play = 1'b0; // bench's expectation that playback consumes samples
   int done_cnt = 0;
   int irq_cnt  = 0;

   mdp_pcm_sched dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .sect_total(sect_total), .pcm_we(pcm_we), .smp_rd(smp_rd),
      .fill_req(fill_req), .fill_ack(fill_ack), .pcm_play(pcm_play),
      .pcm_addr_rst(pcm_addr_rst), .busy(busy), .done(done), .underrun(underrun),
      .low_irq(low_irq), .level(level)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // One clock: inputs held across the edge, outputs sampled 1 time unit after it.
   task automatic tick(input logic we, input logic rd, input logic ack);
      int nxt;
      pcm_we = we; smp_rd = rd; fill_ack = ack;
      nxt = m_level;
      if (we && m_level < CAP) nxt = nxt + 1;
      if (rd && exp_play && m_level >= 4) nxt = nxt - 4;
      m_level = nxt;
      @(posedge clk); #1;
      pcm_we = 1'b0; smp_rd = 1'b0; fill_ack = 1'b0;
      if (done) done_cnt++;
      if (low_irq) irq_cnt++;
   endtask

   task automatic do_start(input int n);
      start = 1'b1; sect_total = 16'(n);
      tick(1'b0, 1'b0, 1'b0);
      start = 1'b0;
      m_level = 0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      stop = 1'b0;
      m_level = 0;
      exp_play = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!fill_req && n < 50) begin
         tick(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk(tag, int'(fill_req), 1);
   endtask

   // Write n bytes with random gaps; optional sparse reads that keep the level high.
   task automatic write_bytes(input int n, input bit rd_ok);
      int cnt = 0;
      logic we, rd;
      while (cnt < n) begin
         we = ($urandom_range(0, 3) != 0);
         rd = rd_ok && exp_play && (m_level >= 3000) && ($urandom_range(0, 3) == 0);
         tick(we, rd, 1'b0);
         if (we) cnt++;
      end
   endtask

   initial begin
      int prev, w1, nb;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_req", int'(fill_req), 0);
      chk("rst_play", int'(pcm_play), 0);
      chk("rst_addr_rst", int'(pcm_addr_rst), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_low_irq", int'(low_irq), 0);

      // start with zero sectors is ignored
      do_start(0);
      chk("zero_start_busy", int'(busy), 0);

      // normal three-sector stream
      do_start(3);
      chk("s1_busy", int'(busy), 1);
      chk("s1_addr_rst", int'(pcm_addr_rst), 0);
      for (int k = 0; k < 3; k++) begin
         wait_req("s1_req");
         write_bytes(SECT, k == 2);
         tick(1'b0, 1'b0, 1'b1);
         chk("s1_req_drop", int'(fill_req), 0);
         chk("s1_level", int'(level), m_level);
         if (k == 0) chk("s1_play_prime", int'(pcm_play), 0);
         if (k == 1) begin
            chk("s1_play_lat", int'(pcm_play), 0);
            tick(1'b0, 1'b0, 1'b0);
            chk("s1_play_on", int'(pcm_play), 1);
            exp_play = 1'b1;
         end
      end
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      chk("s1_no_more_req", int'(fill_req), 0);
      irq_cnt = 0;
      done_cnt = 0;
      while (m_level >= 4) begin
         prev = m_level;
         tick(1'b0, 1'b1, 1'b0);
         chk("s1_drain_irq", int'(low_irq),
             (IRQ_ON != 0 && prev >= LOWWM && m_level < LOWWM) ? 1 : 0);
      end
      chk("s1_irq_count", irq_cnt, IRQ_ON);
      chk("s1_drained_level", int'(level), 0);
      chk("s1_done_early", int'(done), 0);
      tick(1'b0, 1'b0, 1'b0);
      chk("s1_done", int'(done), 1);
      tick(1'b0, 1'b0, 1'b0);
      exp_play = 1'b0;
      chk("s1_done_once", done_cnt, 1);
      chk("s1_idle_busy", int'(busy), 0);
      chk("s1_idle_play", int'(pcm_play), 0);
      chk("s1_idle_addr_rst", int'(pcm_addr_rst), 1);

      // underrun and recovery
      do_start(4);
      for (int k = 0; k < 2; k++) begin
         wait_req("s2_req");
         write_bytes(SECT, 1'b0);
         tick(1'b0, 1'b0, 1'b1);
      end
      tick(1'b0, 1'b0, 1'b0);
      chk("s2_play_on", int'(pcm_play), 1);
      exp_play = 1'b1;
      wait_req("s2_req3");
      while (m_level >= 4) tick(1'b0, 1'b1, 1'b0);
      chk("s2_no_underrun_yet", int'(underrun), 0);
      tick(1'b0, 1'b0, 1'b0);
      chk("s2_underrun", int'(underrun), 1);
      tick(1'b0, 1'b0, 1'b0);
      chk("s2_play_off", int'(pcm_play), 0);
      exp_play = 1'b0;
      write_bytes(SECT, 1'b0);
      repeat (8) tick(1'b0, 1'b1, 1'b0);
      chk("s2_rd_ignored", int'(level), m_level);
      tick(1'b0, 1'b0, 1'b1);
      wait_req("s2_req4");
      write_bytes(SECT, 1'b0);
      chk("s2_refilled", int'(level), 2 * SECT);
      chk("s2_still_off", int'(pcm_play), 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("s2_resume", int'(pcm_play), 1);
      chk("s2_sticky", int'(underrun), 1);
      do_stop();
      chk("s2_stop_keeps_ur", int'(underrun), 1);
      chk("s2_stop_level", int'(level), 0);

      // looping single-sector stream never finishes
      loop_en = 1'b1;
      do_start(1);
      chk("s3_ur_cleared", int'(underrun), 0);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         wait_req("s3_req");
         tick(1'b0, 1'b0, 1'b1);
      end
      wait_req("s3_req_again");
      repeat (4) tick(1'b0, 1'b0, 1'b0);
      chk("s3_no_done", done_cnt, 0);
      chk("s3_busy", int'(busy), 1);
      chk("s3_underrun", int'(underrun), 1);
      do_stop();
      loop_en = 1'b0;

      // stop with a request outstanding; late ack ignored
      do_start(5);
      wait_req("s4_req");
      nb = $urandom_range(10, 100);
      write_bytes(nb, 1'b0);
      chk("s4_level", int'(level), nb);
      do_stop();
      chk("s4_req", int'(fill_req), 0);
      chk("s4_busy", int'(busy), 0);
      chk("s4_addr_rst", int'(pcm_addr_rst), 1);
      chk("s4_level0", int'(level), 0);
      tick(1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      chk("s4_late_ack_req", int'(fill_req), 0);
      chk("s4_late_ack_busy", int'(busy), 0);
      chk("s4_late_ack_lvl", int'(level), 0);

      // simultaneous write and read
      do_start(2);
      w1 = $urandom_range(20, 60);
      wait_req("s5_req1");
      write_bytes(w1, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      wait_req("s5_req2");
      write_bytes(100 - w1, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      chk("s5_play", int'(pcm_play), 1);
      exp_play = 1'b1;
      chk("s5_level100", int'(level), 100);
      tick(1'b1, 1'b1, 1'b0);
      chk("s5_level97", int'(level), 97);
      done_cnt = 0;
      while (m_level >= 4) tick(1'b0, 1'b1, 1'b0);
      chk("s5_residue", int'(level), 1);
      repeat (2) tick(1'b0, 1'b0, 1'b0);
      exp_play = 1'b0;
      chk("s5_done", done_cnt, 1);
      chk("s5_idle", int'(busy), 0);

      // stop and start together: stop wins
      stop = 1'b1;
      do_start(3);
      stop = 1'b0;
      chk("s6_stop_wins", int'(busy), 0);

      // saturation, free-space gating, restart while busy
      do_start(5);
      wait_req("s6_req");
      write_bytes(CAP + 5, 1'b0);
      chk("s6_sat", int'(level), CAP);
      chk("s6_sat_model", int'(level), m_level);
      tick(1'b0, 1'b0, 1'b1);
      repeat (5) tick(1'b0, 1'b0, 1'b0);
      chk("s6_no_room_req", int'(fill_req), 0);
      chk("s6_busy", int'(busy), 1);
      do_start(2);
      chk("s6_restart_lvl", int'(level), 0);
      chk("s6_restart_busy", int'(busy), 1);
      chk("s6_restart_req", int'(fill_req), 0);
      wait_req("s6_restart_req2");
      do_stop();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
